// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_tx_arbiter_pkg;

   // Arbiter FSM: IDLE arbitrates, XFER streams one packet from the granted requester.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   localparam int DEF_N_REQ       = 3;
   localparam int DEF_MAX_PKT_LEN = 64;
   localparam int DEF_CNT_W       = 7;

   // Grant index width; covers up to 8 requesters.
   localparam int GID_W = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after the last grant, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   i_req        request vector, one bit per requester
//   i_last_grant index granted most recently; search starts just after it
//   o_pick       chosen index (i_last_grant when nothing requests)
//   o_any        at least one request present
module uart_tx_arbiter_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [GID_W-1:0] i_last_grant,
   output logic [GID_W-1:0] o_pick,
   output logic             o_any
);

   assign o_any = |i_req;

   // Each requester gets a rotational distance from the slot after the last
   // grant; the smallest distance among the active requests wins.
   always_comb begin : p_pick
      int best_d;
      int d;
      best_d = N_REQ;
      d      = 0;
      o_pick = i_last_grant;
      for (int i = 0; i < N_REQ; i++) begin
         d = (i + 2 * N_REQ - int'(i_last_grant) - 1) % N_REQ;
         if (i_req[i] && (d < best_d)) begin
            best_d = d;
            o_pick = GID_W'(i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N byte streams; round-robin grant held per packet.
// Latency: request in IDLE -> first ready next cycle; accepted byte visible on tx side next cycle.
// Backpressure: ready to the granted requester only when the one-byte holding register can load.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req_valid/_data/_last per-requester byte stream (data packed 8 bits per requester)
//   o_req_ready            per-requester accept strobe (valid && ready = byte taken)
//   o_tx_data              byte presented to the UART transmitter
//   o_tx_buf_not_empty     o_tx_data holds an unsent byte
//   i_tx_read_buf          one-cycle pop from the transmitter
//   o_grant_id             current or most recent grant
//   o_busy                 packet in progress or byte still held
//   o_trunc_err            one-cycle pulse when a packet is cut at MAX_PKT_LEN
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ       = DEF_N_REQ,
   parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N_REQ-1:0]     i_req_valid,
   input  logic [8*N_REQ-1:0]   i_req_data,
   input  logic [N_REQ-1:0]     i_req_last,
   output logic [N_REQ-1:0]     o_req_ready,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_buf_not_empty,
   input  logic                 i_tx_read_buf,
   output logic [GID_W-1:0]     o_grant_id,
   output logic                 o_busy,
   output logic                 o_trunc_err
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [GID_W-1:0]   r_rr_ptr;
   logic [GID_W-1:0]   r_grant_id;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_hold_valid;
   logic [7:0]         r_hold_data;
   logic               r_trunc_err;

   logic [GID_W-1:0]   w_pick;
   logic               w_any;
   logic               w_sel_vld;
   logic               w_sel_last;
   logic [7:0]         w_sel_dat;
   logic               w_can_load;
   logic               w_grant_rdy;
   logic               w_accept;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_cnt_max;

   uart_tx_arbiter_rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .i_req        (i_req_valid),
      .i_last_grant (r_rr_ptr),
      .o_pick       (w_pick),
      .o_any        (w_any)
   );

   // Mux out the granted requester's stream.
   always_comb begin
      w_sel_vld  = 1'b0;
      w_sel_last = 1'b0;
      w_sel_dat  = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant_id == GID_W'(i)) begin
            w_sel_vld  = i_req_valid[i];
            w_sel_last = i_req_last[i];
            w_sel_dat  = i_req_data[8*i +: 8];
         end
      end
   end

   // A pop in the same cycle frees the register, so loading stays at one byte per cycle.
   assign w_can_load  = !r_hold_valid || i_tx_read_buf;
   // Ready is suppressed during reset so no byte is consumed from a stream being dropped.
   assign w_grant_rdy = (r_state == ST_XFER) && w_can_load && !i_rst;
   assign w_accept    = w_grant_rdy && w_sel_vld;
   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_cnt_max   = (w_cnt_inc == CNT_W'(MAX_PKT_LEN));

   always_comb begin
      o_req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         o_req_ready[i] = w_grant_rdy && (r_grant_id == GID_W'(i));
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_any) w_state_nxt = ST_XFER;
         ST_XFER: if (w_accept && (w_sel_last || w_cnt_max)) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= GID_W'(N_REQ - 1);
         r_grant_id   <= '0;
         r_cnt        <= '0;
         r_hold_valid <= 1'b0;
         r_hold_data  <= 8'h00;
         r_trunc_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         // Last wins over length: a packet ending exactly at the limit is not a truncation.
         r_trunc_err <= w_accept && !w_sel_last && w_cnt_max;
         if ((r_state == ST_IDLE) && w_any) begin
            r_grant_id <= w_pick;
            r_rr_ptr   <= w_pick;
            r_cnt      <= '0;
         end
         if (w_accept) begin
            r_hold_data  <= w_sel_dat;
            r_hold_valid <= 1'b1;
            r_cnt        <= w_cnt_inc;
         end else if (i_tx_read_buf) begin
            r_hold_valid <= 1'b0;
         end
      end
   end

   assign o_tx_data          = r_hold_data;
   assign o_tx_buf_not_empty = r_hold_valid;
   assign o_grant_id         = r_grant_id;
   assign o_busy             = (r_state == ST_XFER) || r_hold_valid;
   assign o_trunc_err        = r_trunc_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for the UART transmit arbiter against a packet-level round-robin model.
// Latency: checks first-ready and first-byte timing on a single packet.
// Backpressure: exercises slow, random and back-to-back transmitter pops.
module tb_uart_tx_arbiter;

   localparam int N    = 3;
   localparam int MAXL = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [8*N-1:0]   req_data;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ready;
   logic [7:0]       tx_data;
   logic             tx_buf_not_empty;
   logic             tx_read_buf;
   logic [2:0]       grant_id;
   logic             busy;
   logic             trunc_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ       (N),
      .MAX_PKT_LEN (MAXL),
      .CNT_W       (3)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_req_valid        (req_valid),
      .i_req_data         (req_data),
      .i_req_last         (req_last),
      .o_req_ready        (req_ready),
      .o_tx_data          (tx_data),
      .o_tx_buf_not_empty (tx_buf_not_empty),
      .i_tx_read_buf      (tx_read_buf),
      .o_grant_id         (grant_id),
      .o_busy             (busy),
      .o_trunc_err        (trunc_err)
   );

   // Per-requester byte streams: {last, data}
   logic [8:0] mem [N][64];
   int         head [N];
   int         tail [N];

   // Expected accepts (src*256+data) and expected transmitted bytes
   int exp_acc[$];
   int exp_pop[$];
   int exp_trunc;
   int m_rr;

   int checks = 0;
   int errors = 0;
   int trunc_seen, first_acc, first_ne, nacc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
   endtask

   task automatic add_byte(input int r, input logic [7:0] d, input logic l);
      mem[r][tail[r]] = {l, d};
      tail[r]++;
   endtask

   task automatic add_pkt(input int r, input int len);
      for (int b = 0; b < len; b++) add_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
   endtask

   task automatic drive();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) begin
         if (head[i] < tail[i]) begin
            req_valid[i]      = 1'b1;
            req_data[8*i +: 8] = mem[i][head[i]][7:0];
            req_last[i]       = mem[i][head[i]][8];
         end
      end
   endtask

   function automatic logic pop_sel(input int mode, input int cyc);
      if (mode == 0) return (cyc % 10) == 9;
      if (mode == 1) return $urandom_range(0, 2) != 0;
      return 1'b1;
   endfunction

   // Packet-level model: every non-empty stream is valid at arbitration time, so the
   // output is round-robin over non-empty queues, each grant taking bytes until last
   // or until MAXL bytes (a truncation).
   task automatic build_model();
      int h [N];
      int pick, cnt, idx;
      logic [8:0] b;
      for (int i = 0; i < N; i++) h[i] = head[i];
      exp_trunc = 0;
      forever begin
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            idx = (m_rr + k) % N;
            if (pick < 0 && h[idx] < tail[idx]) pick = idx;
         end
         if (pick < 0) break;
         m_rr = pick;
         cnt  = 0;
         while (h[pick] < tail[pick]) begin
            b = mem[pick][h[pick]];
            h[pick]++;
            exp_acc.push_back(pick * 256 + int'(b[7:0]));
            exp_pop.push_back(int'(b[7:0]));
            cnt++;
            if (b[8]) break;
            if (cnt == MAXL) begin
               exp_trunc++;
               break;
            end
         end
      end
   endtask

   // Runs the loaded streams through the DUT. Entered and left just after a rising edge.
   task automatic run_phase(input int mode, input int stop_acc, input int budget);
      int cyc;
      int accepted [N];
      int e;
      build_model();
      trunc_seen = 0;
      first_acc  = -1;
      first_ne   = -1;
      nacc       = 0;
      cyc        = 0;
      drive();
      tx_read_buf = pop_sel(mode, 0);
      while (cyc < budget && (exp_pop.size() > 0 || exp_acc.size() > 0)) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            accepted[i] = 0;
            if (req_valid[i] && req_ready[i]) begin
               accepted[i] = 1;
               nacc++;
               if (first_acc < 0) first_acc = cyc;
               e = (exp_acc.size() > 0) ? exp_acc.pop_front() : -1;
               chk("accept_src_data", i * 256 + int'(req_data[8*i +: 8]), e);
            end
         end
         chk("ready_onehot", ($countones(req_ready) <= 1), 1);
         if (tx_read_buf && tx_buf_not_empty) begin
            e = (exp_pop.size() > 0) ? exp_pop.pop_front() : -1;
            chk("tx_byte", tx_data, e);
         end
         if (tx_buf_not_empty && first_ne < 0) first_ne = cyc;
         if (trunc_err) trunc_seen++;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) if (accepted[i] != 0) head[i]++;
         cyc++;
         drive();
         tx_read_buf = pop_sel(mode, cyc);
         if (stop_acc > 0 && nacc >= stop_acc) break;
      end
      if (stop_acc == 0) begin
         chk("left_accepts", exp_acc.size(), 0);
         chk("left_bytes", exp_pop.size(), 0);
         chk("trunc_count", trunc_seen, exp_trunc);
         tx_read_buf = 1'b0;
         @(negedge clk);
         chk("busy_end", busy, 0);
         chk("not_empty_end", tx_buf_not_empty, 0);
         chk("trunc_end", trunc_err, 0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      req_valid   = 3'b111;
      req_data    = 24'h030201;
      req_last    = '0;
      tx_read_buf = 1'b0;
      m_rr        = N - 1;
      clear_q();

      // Reset with all requests pending
      repeat (2) begin
         @(negedge clk);
         chk("reset_ready", req_ready, 0);
         chk("reset_not_empty", tx_buf_not_empty, 0);
         chk("reset_busy", busy, 0);
         chk("reset_trunc", trunc_err, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = '0;

      // Single packet, slow pops
      add_byte(0, 8'h41, 1'b0);
      add_byte(0, 8'h42, 1'b0);
      add_byte(0, 8'h0A, 1'b1);
      run_phase(0, 0, 200);
      chk("first_ready_cycle", first_acc, 1);
      chk("first_not_empty_cycle", first_ne, 2);
      chk("grant_single", grant_id, 0);

      // Round-robin with all requesters sending 2-byte packets
      clear_q();
      for (int p = 0; p < 3; p++) for (int r = 0; r < N; r++) add_pkt(r, 2);
      run_phase(1, 0, 500);
      chk("grant_rr", grant_id, m_rr);

      // Truncation: 6-byte stream from requester 1
      clear_q();
      add_pkt(1, 6);
      run_phase(2, 0, 200);
      chk("trunc_once", trunc_seen, 1);

      // Pops while empty change nothing
      tx_read_buf = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_pop_not_empty", tx_buf_not_empty, 0);
         chk("idle_pop_busy", busy, 0);
         chk("idle_pop_grant", grant_id, m_rr);
      end
      @(posedge clk);
      #1;
      tx_read_buf = 1'b0;

      // Random traffic, back-to-back and random pops
      for (int it = 0; it < 4; it++) begin
         clear_q();
         for (int r = 0; r < N; r++)
            for (int p = 0; p < 3; p++)
               if ($urandom_range(0, 3) != 0) add_pkt(r, $urandom_range(1, 6));
         run_phase((it % 2 == 0) ? 2 : 1, 0, 1000);
      end

      // Reset after 2 of 5 bytes from requester 2
      clear_q();
      for (int b = 0; b < 5; b++) add_byte(2, 8'(8'hB0 + b), b == 4);
      run_phase(2, 2, 100);
      rst = 1'b1;
      clear_q();
      drive();
      exp_acc.delete();
      exp_pop.delete();
      m_rr = N - 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_not_empty", tx_buf_not_empty, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_grant", grant_id, 0);
      @(posedge clk);
      #1;

      // Pointer reset: grant 0, reset, then 0 and 2 compete -> 0 must win
      clear_q();
      add_pkt(0, 1);
      run_phase(1, 0, 100);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      m_rr = N - 1;
      clear_q();
      add_pkt(2, 2);
      add_pkt(0, 2);
      run_phase(1, 0, 200);
      chk("grant_after_ptr_reset", grant_id, m_rr);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
